rv_pipe_ctrl: RTL and testbench



---
 rtl/rv_pipe_pkg.sv | 35 +++
 rtl/rv_hazard_cmp.sv | 16 +
 rtl/rv_pipe_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_rv_pipe_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared types for the pipeline sequencing controller.
// FSM state encoding, forwarding select codes and the x0 constant.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    FLUSH = 2'd2,
    FWAIT = 2'd3
  } pipe_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // E producer is one stage closer, so it wins over M.
  function automatic fwd_sel_t fwd_pick(
    input logic e_hit,
    input logic m_hit
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (e_hit) begin
      sel = FWD_M;
    end else if (m_hit) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rv_hazard_cmp.sv
// One source register against one stage destination.
// Hit when rs is not x0, matches rd, and the stage writes rd.
module rv_hazard_cmp
  import rv_pipe_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd,
  input  logic       i_reg_write,
  output logic       o_hit
);

  assign o_hit = (i_rs != REG_X0)
              && (i_rs == i_rd)
              && i_reg_write;

endmodule

// File: rtl/rv_pipe_ctrl.sv
// Stall/flush sequencing and forwarding selects for the 5-stage core.
// RV_HAZARD_FWD_EN enables operand forwarding (load-use bubble only).
module rv_pipe_ctrl
  import rv_pipe_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_d_rs1,
  input  logic [4:0] i_d_rs2,
  input  logic [4:0] i_e_rd,
  input  logic [4:0] i_m_rd,
  input  logic       i_e_reg_write,
  input  logic       i_m_reg_write,
  input  logic       i_e_mem_read,
  input  logic       i_e_pc_change,
  input  logic       i_f_ack,
  input  logic       i_m_busy,
  output logic       o_f_stall,
  output logic       o_d_stall,
  output logic       o_e_stall,
  output logic       o_m_stall,
  output logic       o_d_flush,
  output logic       o_e_flush,
  output logic       o_w_flush,
  output logic [1:0] o_fwd_rs1,
  output logic [1:0] o_fwd_rs2
);

  pipe_state_t state_q, state_d;

  logic e1_hit, e2_hit;
  logic m1_hit, m2_hit;
  logic ld_use;
  logic stall_hz;
  pipe_state_t hz_state;

  logic f_stall, d_stall;
  logic e_stall, m_stall;
  logic d_flush, e_flush;
  logic w_flush;

  rv_hazard_cmp u_cmp_e1 (
    .i_rs        (i_d_rs1),
    .i_rd        (i_e_rd),
    .i_reg_write (i_e_reg_write),
    .o_hit       (e1_hit)
  );

  rv_hazard_cmp u_cmp_e2 (
    .i_rs        (i_d_rs2),
    .i_rd        (i_e_rd),
    .i_reg_write (i_e_reg_write),
    .o_hit       (e2_hit)
  );

  rv_hazard_cmp u_cmp_m1 (
    .i_rs        (i_d_rs1),
    .i_rd        (i_m_rd),
    .i_reg_write (i_m_reg_write),
    .o_hit       (m1_hit)
  );

  rv_hazard_cmp u_cmp_m2 (
    .i_rs        (i_d_rs2),
    .i_rd        (i_m_rd),
    .i_reg_write (i_m_reg_write),
    .o_hit       (m2_hit)
  );

  assign ld_use = i_e_mem_read
               & (e1_hit | e2_hit);

`ifdef RV_HAZARD_FWD_EN
  assign stall_hz = ld_use;
  assign hz_state = LDUSE;
`else
  // Without forwarding every RAW waits for the write-through regfile.
  assign stall_hz = ld_use
                  | e1_hit | e2_hit
                  | m1_hit | m2_hit;
  assign hz_state = RUN;
`endif

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and stall/flush strobes, by priority
  always_comb begin
    state_d = state_q;
    f_stall = 1'b0;
    d_stall = 1'b0;
    e_stall = 1'b0;
    m_stall = 1'b0;
    d_flush = 1'b0;
    e_flush = 1'b0;
    w_flush = 1'b0;
    if (i_reset) begin
      d_flush = 1'b1;
      e_flush = 1'b1;
      w_flush = 1'b1;
      state_d = RUN;
    end else if (i_m_busy) begin
      f_stall = 1'b1;
      d_stall = 1'b1;
      e_stall = 1'b1;
      m_stall = 1'b1;
      w_flush = 1'b1;
    end else if (i_e_pc_change) begin
      d_flush = 1'b1;
      e_flush = 1'b1;
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        FLUSH: begin
          // Kill the word already in flight.
          d_flush = 1'b1;
          state_d = RUN;
        end
        LDUSE: begin
          state_d = RUN;
        end
        default: begin
          if (stall_hz) begin
            f_stall = 1'b1;
            d_stall = 1'b1;
            e_flush = 1'b1;
            state_d = hz_state;
          end else if (!i_f_ack) begin
            f_stall = 1'b1;
            d_stall = 1'b1;
            e_flush = 1'b1;
            state_d = FWAIT;
          end else begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  assign o_f_stall = f_stall;
  assign o_d_stall = d_stall;
  assign o_e_stall = e_stall;
  assign o_m_stall = m_stall;
  assign o_d_flush = d_flush;
  assign o_e_flush = e_flush;
  assign o_w_flush = w_flush;

`ifdef RV_HAZARD_FWD_EN
  fwd_sel_t fwd_rs1_q, fwd_rs1_d;
  fwd_sel_t fwd_rs2_q, fwd_rs2_d;

  // Next forwarding selects, loaded as D advances into E
  always_comb begin
    fwd_rs1_d = fwd_rs1_q;
    fwd_rs2_d = fwd_rs2_q;
    if (!e_stall) begin
      if (e_flush) begin
        fwd_rs1_d = FWD_RF;
        fwd_rs2_d = FWD_RF;
      end else begin
        fwd_rs1_d = fwd_pick(e1_hit, m1_hit);
        fwd_rs2_d = fwd_pick(e2_hit, m2_hit);
      end
    end
  end

  // Forwarding select registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fwd_rs1_q <= FWD_RF;
      fwd_rs2_q <= FWD_RF;
    end else begin
      fwd_rs1_q <= fwd_rs1_d;
      fwd_rs2_q <= fwd_rs2_d;
    end
  end

  assign o_fwd_rs1 = fwd_rs1_q;
  assign o_fwd_rs2 = fwd_rs2_q;
`else
  assign o_fwd_rs1 = FWD_RF;
  assign o_fwd_rs2 = FWD_RF;
`endif

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Directed bench for rv_pipe_ctrl with a queue-based scoreboard.
// Expectations follow RV_HAZARD_FWD_EN when it is defined.
module tb_rv_pipe_ctrl;

`ifdef RV_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [4:0] rs1, rs2;
  logic [4:0] erd, mrd;
  logic       ewr, mwr;
  logic       eld, pc;
  logic       ack, busy;
  logic       f_st, d_st;
  logic       e_st, m_st;
  logic       d_fl, e_fl, w_fl;
  logic [1:0] fw1, fw2;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] fl;
    logic [1:0] f1;
    logic [1:0] f2;
    int         n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;

  rv_pipe_ctrl dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_d_rs1       (rs1),
    .i_d_rs2       (rs2),
    .i_e_rd        (erd),
    .i_m_rd        (mrd),
    .i_e_reg_write (ewr),
    .i_m_reg_write (mwr),
    .i_e_mem_read  (eld),
    .i_e_pc_change (pc),
    .i_f_ack       (ack),
    .i_m_busy      (busy),
    .o_f_stall     (f_st),
    .o_d_stall     (d_st),
    .o_e_stall     (e_st),
    .o_m_stall     (m_st),
    .o_d_flush     (d_fl),
    .o_e_flush     (e_fl),
    .o_w_flush     (w_fl),
    .o_fwd_rs1     (fw1),
    .o_fwd_rs2     (fw2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rst  = 1'b0;
    rs1  = 5'd0;
    rs2  = 5'd0;
    erd  = 5'd0;
    mrd  = 5'd0;
    ewr  = 1'b0;
    mwr  = 1'b0;
    eld  = 1'b0;
    pc   = 1'b0;
    ack  = 1'b1;
    busy = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
    cyc_n++;
  endtask

  task automatic exp(
    input logic [3:0] st,
    input logic [2:0] fl,
    input logic [1:0] f1,
    input logic [1:0] f2
  );
    exp_t e;
    e.st = st;
    e.fl = fl;
    e.f1 = f1;
    e.f2 = f2;
    e.n  = cyc_n;
    sb.push_back(e);
  endtask

  // Monitor: pop one expectation per cycle, compare mid-cycle
  initial begin
    exp_t e;
    logic [3:0] a_st;
    logic [2:0] a_fl;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a_st = {f_st, d_st, e_st, m_st};
        a_fl = {d_fl, e_fl, w_fl};
        checks++;
        if (a_st !== e.st) begin
          errors++;
          $display("FAIL stall cyc %0d: got %b want %b",
                   e.n, a_st, e.st);
        end
        checks++;
        if (a_fl !== e.fl) begin
          errors++;
          $display("FAIL flush cyc %0d: got %b want %b",
                   e.n, a_fl, e.fl);
        end
        checks++;
        if ({fw1, fw2} !== {e.f1, e.f2}) begin
          errors++;
          $display("FAIL fwd cyc %0d: got %b/%b want %b/%b",
                   e.n, fw1, fw2, e.f1, e.f2);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // reset state
    nxt(); rst = 1'b1;
    exp(4'b0000, 3'b111, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00, 2'b00);

    // load to x5 in E, D reads x5
    nxt(); rs1 = 5'd5; erd = 5'd5; ewr = 1; eld = 1;
    exp(4'b1100, 3'b010, 2'b00, 2'b00);
    nxt(); rs1 = 5'd5; mrd = 5'd5; mwr = 1;
    exp(FWD ? 4'b0000 : 4'b1100,
        FWD ? 3'b000 : 3'b010, 2'b00, 2'b00);
    nxt(); rs1 = 5'd5; erd = 5'd6; ewr = 1;
    exp(4'b0000, 3'b000,
        FWD ? 2'b10 : 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00, 2'b00);

    // ALU result to x3 in E, D rs2 = x3
    nxt(); rs2 = 5'd3; erd = 5'd3; ewr = 1;
    exp(FWD ? 4'b0000 : 4'b1100,
        FWD ? 3'b000 : 3'b010, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00,
        FWD ? 2'b01 : 2'b00);
    // same with rd = x0
    nxt(); rs2 = 5'd0; erd = 5'd0; ewr = 1;
    exp(4'b0000, 3'b000, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00, 2'b00);

    // M-only match on rs2
    nxt(); rs2 = 5'd7; mrd = 5'd7; mwr = 1;
    exp(FWD ? 4'b0000 : 4'b1100,
        FWD ? 3'b000 : 3'b010, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00,
        FWD ? 2'b10 : 2'b00);

    // E and M both match rs1: E wins
    nxt(); rs1 = 5'd9; erd = 5'd9; ewr = 1;
    mrd = 5'd9; mwr = 1;
    exp(FWD ? 4'b0000 : 4'b1100,
        FWD ? 3'b000 : 3'b010, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000,
        FWD ? 2'b01 : 2'b00, 2'b00);

    // reg_write low: no match
    nxt(); rs1 = 5'd4; rs2 = 5'd4; erd = 5'd4;
    mrd = 5'd4; eld = 1;
    exp(4'b0000, 3'b000, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00, 2'b00);

    // redirect; flushed E loads fwd 00
    nxt(); pc = 1; rs1 = 5'd5; erd = 5'd5; ewr = 1;
    exp(4'b0000, 3'b110, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b100, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00, 2'b00);

    // busy 3 cycles with redirect pending
    nxt(); rs1 = 5'd3; erd = 5'd3; ewr = 1;
    exp(FWD ? 4'b0000 : 4'b1100,
        FWD ? 3'b000 : 3'b010, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      nxt(); busy = 1; pc = 1;
      exp(4'b1111, 3'b001,
          FWD ? 2'b01 : 2'b00, 2'b00);
    end
    nxt(); pc = 1;
    exp(4'b0000, 3'b110,
        FWD ? 2'b01 : 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b100, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00, 2'b00);

    // busy overrides load-use
    nxt(); busy = 1; rs1 = 5'd5; erd = 5'd5;
    ewr = 1; eld = 1;
    exp(4'b1111, 3'b001, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00, 2'b00);

    // fetch wait 4 cycles
    for (int i = 0; i < 4; i++) begin
      nxt(); ack = 0;
      exp(4'b1100, 3'b010, 2'b00, 2'b00);
    end
    nxt();
    exp(4'b0000, 3'b000, 2'b00, 2'b00);

    // reset during fetch wait
    nxt(); ack = 0;
    exp(4'b1100, 3'b010, 2'b00, 2'b00);
    nxt(); ack = 0; rst = 1;
    exp(4'b0000, 3'b111, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00, 2'b00);

    // reset during FLUSH
    nxt(); pc = 1;
    exp(4'b0000, 3'b110, 2'b00, 2'b00);
    nxt(); rst = 1;
    exp(4'b0000, 3'b111, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00, 2'b00);

    // ack together with redirect in FWAIT
    nxt(); ack = 0;
    exp(4'b1100, 3'b010, 2'b00, 2'b00);
    nxt(); pc = 1;
    exp(4'b0000, 3'b110, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b100, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00, 2'b00);

    // redirect abandons the load-use bubble
    nxt(); rs1 = 5'd5; erd = 5'd5; ewr = 1; eld = 1;
    exp(4'b1100, 3'b010, 2'b00, 2'b00);
    nxt(); pc = 1; rs1 = 5'd5; mrd = 5'd5; mwr = 1;
    exp(4'b0000, 3'b110, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b100, 2'b00, 2'b00);
    nxt();
    exp(4'b0000, 3'b000, 2'b00, 2'b00);

    // drain the scoreboard, bounded
    for (int i = 0; i < 4; i++) begin
      if (sb.size() != 0) @(posedge clk);
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
